// File: rtl/dr_pay_collector.sv
// Payment collector for a drink vending machine: accumulates coins, then either hands the
// total and selected code to the drink stage or refunds it on cancel or idle timeout.
module dr_pay_collector #(
    parameter int unsigned MAX_PAY = 1000,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [7:0] sel_code,
    input  logic       cancel,
    output logic       valid,
    output logic [9:0] pay_in,
    output logic [7:0] code,
    output logic       refund_valid,
    output logic [9:0] refund_amt,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SEND,
        REFUND
    } state_t;

    state_t          state_q;
    logic [9:0]      total_q;
    logic [IW-1:0]   idle_q;
    logic            valid_q;
    logic [9:0]      pay_q;
    logic [7:0]      code_q;
    logic            refund_valid_q;
    logic [9:0]      refund_amt_q;
    logic            coin_reject_q;
    logic            busy_q;

    logic [9:0]      coin_amt;
    logic [10:0]     sum_d;
    logic            coin_fits;
    logic [9:0]      total_d;
    logic            any_event;

    always_comb begin
        coin_amt = '0;
        case (coin_val)
            2'b00:   coin_amt = 10'd1;
            2'b01:   coin_amt = 10'd2;
            2'b10:   coin_amt = 10'd5;
            default: coin_amt = 10'd10;
        endcase
        sum_d     = {1'b0, total_q} + {1'b0, coin_amt};
        coin_fits = (sum_d <= 11'(MAX_PAY));
        total_d   = (coin_valid && coin_fits) ? sum_d[9:0] : total_q;
        any_event = coin_valid | sel_valid | cancel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            total_q        <= '0;
            idle_q         <= '0;
            valid_q        <= 1'b0;
            pay_q          <= '0;
            code_q         <= '0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            valid_q        <= 1'b0;
            refund_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (coin_valid) begin
                        total_q <= coin_amt;
                        idle_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    // The same-cycle coin is folded into total_d before cancel/select act on it
                    if (coin_valid && !coin_fits)
                        coin_reject_q <= 1'b1;
                    total_q <= total_d;
                    if (cancel) begin
                        refund_valid_q <= 1'b1;
                        refund_amt_q   <= total_d;
                        state_q        <= REFUND;
                    end else if (sel_valid) begin
                        valid_q <= 1'b1;
                        pay_q   <= total_d;
                        code_q  <= sel_code;
                        state_q <= SEND;
                    end else if (!any_event && idle_q == IW'(TIMEOUT - 2)) begin
                        refund_valid_q <= 1'b1;
                        refund_amt_q   <= total_d;
                        state_q        <= REFUND;
                    end
                    idle_q <= any_event ? '0 : idle_q + 1'b1;
                end
                default: begin
                    if (coin_valid)
                        coin_reject_q <= 1'b1;
                    total_q <= '0;
                    idle_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign valid        = valid_q;
    assign pay_in       = pay_q;
    assign code         = code_q;
    assign refund_valid = refund_valid_q;
    assign refund_amt   = refund_amt_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule

// File: doc/dr_pay_collector.md
DR_PAY_COLLECTOR -- requirements
Module: dr_pay_collector

Interface
REQ-001 Parameter MAX_PAY, default 1000, is the maximum accumulated payment (must be <= 1023).
REQ-002 Parameter TIMEOUT, default 1000, is the number of idle cycles in COLLECT before an automatic refund.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 coin_valid  input  1  one-cycle strobe: a coin is inserted this cycle.
REQ-006 coin_val  input  2  coin denomination: 00=1, 01=2, 10=5, 11=10 units.
REQ-007 sel_valid  input  1  one-cycle strobe: a drink selection is made this cycle.
REQ-008 sel_code  input  8  drink code qualified by sel_valid.
REQ-009 cancel  input  1  one-cycle strobe: customer requests a refund.
REQ-010 valid  output  1  one-cycle strobe to the drink stage: pay_in and code are valid.
REQ-011 pay_in  output  10  accumulated payment, qualified by valid.
REQ-012 code  output  8  latched selection, qualified by valid.
REQ-013 refund_valid  output  1  one-cycle strobe: refund_amt is valid.
REQ-014 refund_amt  output  10  amount returned, qualified by refund_valid.
REQ-015 coin_reject  output  1  one-cycle strobe: the coin offered this cycle was refused.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, COLLECT, SEND and REFUND; all outputs SHALL be registered.
REQ-018 IDLE, coin_valid: add coin to total (total starts at 0), go to COLLECT.
REQ-019 IDLE: sel_valid and cancel SHALL be ignored; no valid or refund_valid is produced.
REQ-020 COLLECT, coin_valid with total+coin <= MAX_PAY: total += coin, using 11-bit intermediate arithmetic.
REQ-021 COLLECT, coin_valid with total+coin > MAX_PAY: total unchanged; coin_reject = 1 in the next cycle.
REQ-022 COLLECT, sel_valid: latch sel_code, go to SEND; a coin in the same cycle is evaluated first, and an accepted coin is included in pay_in.
REQ-023 COLLECT, cancel: go to REFUND; cancel SHALL win over a same-cycle sel_valid; a same-cycle coin is still evaluated and, if accepted, included in refund_amt.
REQ-024 COLLECT: an idle counter SHALL count cycles with none of coin_valid, sel_valid or cancel; it clears on any of them and on entry to COLLECT.
REQ-025 COLLECT: when the idle counter reaches TIMEOUT-1 with no event that cycle, go to REFUND.
REQ-026 SEND: valid = 1, pay_in = total, code = latched code, for exactly one cycle, then go to IDLE with total = 0.
REQ-027 REFUND: refund_valid = 1, refund_amt = total, for exactly one cycle, then go to IDLE with total = 0.
REQ-028 SEND or REFUND, coin_valid: the coin SHALL be rejected (coin_reject = 1 next cycle); sel_valid and cancel SHALL be ignored.
REQ-029 Latency: sel_valid or cancel sampled in cycle N gives valid or refund_valid high in cycle N+1.
REQ-030 valid and refund_valid SHALL never be high in the same cycle.
REQ-031 pay_in, code and refund_amt SHALL hold their last values while their strobe is low.

Reset
REQ-032 When rst is high at a clock edge, the block SHALL take these values on that edge:
- state IDLE
- total, idle counter, latched code = 0
- valid, refund_valid, coin_reject, busy = 0
- pay_in, refund_amt, code = 0
REQ-033 Reset during COLLECT, SEND or REFUND SHALL discard the accumulated total; no refund_valid or valid is emitted for it.

Verification
REQ-034 Coins 5, 10, 2, then sel_code=0x21 -> one-cycle valid, pay_in=17, code=0x21, one cycle after sel_valid; busy then low.
REQ-035 With total=995, insert coin 10 -> coin_reject=1, total stays 995; insert coin 5 -> accepted; sel -> pay_in=1000.
REQ-036 Coin 5 and coin 2, then cancel and sel_valid in the same cycle -> refund_valid=1, refund_amt=7, valid never asserted.
REQ-037 TIMEOUT=8, one coin 10, then no activity -> refund_valid with refund_amt=10 exactly 8 cycles after the coin cycle.
REQ-038 Coin 2 accepted, then rst mid-COLLECT, then sel_valid -> no valid, no refund_valid, all outputs 0, busy=0.
REQ-039 Coin 1 and sel_valid in the same cycle during COLLECT (total 4) -> pay_in=5; a coin during the SEND cycle -> coin_reject=1.
